// File: rtl/mem_pkg.sv
// Shared types and widths for the memory responder and its RAM.
// No logic; compile before the other rtl files.
// Loader FSM state encoding lives here so every file agrees on it.
package mem_pkg;

  localparam int HALFWORD_W = 16;
  localparam int BYTE_W     = 8;

  typedef enum logic [1:0] {
    IDLE,
    BYTE0,
    BYTE1,
    DONE
  } ld_state_t;

endpackage

// File: rtl/mem_ram.sv
// Single-port DEPTH x 16 synchronous RAM, read-first on a same-cycle read/write.
// Latency: read data appears on rdata_o the cycle after re_i; it holds otherwise.
// Backpressure: none, the RAM accepts one access every cycle.
module mem_ram
  import mem_pkg::*;
#(
  parameter int DEPTH = 4096,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic                  re_i,
  input  logic [AW-1:0]         addr_i,
  input  logic [HALFWORD_W-1:0] wdata_i,
  output logic [HALFWORD_W-1:0] rdata_o
);

  logic [HALFWORD_W-1:0] r_mem [DEPTH];
  logic [HALFWORD_W-1:0] r_q;

  // Write and read in the same edge; the read sees the pre-write word.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      r_mem[addr_i] <= wdata_i;
    end
    if (re_i) begin
      r_q <= r_mem[addr_i];
    end
  end

  assign rdata_o = r_q;

endmodule

// File: rtl/mem_responder.sv
// Memory responder for the shared 16-bit port, plus a byte-stream program loader.
// Latency: reads return the next cycle; a load ends with load_done_o one cycle after its last byte.
// Backpressure: load_ready_o gates loader bytes; arbiter requests are ignored while load_busy_o.
// Optional: MEM_LOAD_CHECKSUM_EN adds checksum_o, the 16-bit wrapping sum of loaded bytes.
module mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH = 4096,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [31:0]           mem_addr_i,
  input  logic                  mem_re_i,
  input  logic                  mem_we_i,
  input  logic [HALFWORD_W-1:0] mem_write_i,
  output logic [HALFWORD_W-1:0] data_o,
  output logic                  addr_err_o,
  input  logic                  load_start_i,
  input  logic [15:0]           load_len_i,
  input  logic [BYTE_W-1:0]     load_byte_i,
  input  logic                  load_valid_i,
  output logic                  load_ready_o,
  output logic                  load_busy_o,
  output logic                  load_done_o
`ifdef MEM_LOAD_CHECKSUM_EN
  ,
  output logic [15:0]           checksum_o
`endif
);

  // Loader state. r_ptr is one bit wider than the RAM index so it can
  // park at DEPTH once the RAM is full; its top bit marks "out of room".
  ld_state_t         r_state;
  logic [15:0]       r_remaining;
  logic [AW:0]       r_ptr;
  logic [BYTE_W-1:0] r_hi;
  logic              r_busy;
  logic              r_ready;
  logic              r_done;
  logic              r_drop_seen;
  logic              r_err;
  logic              r_zero;

  logic                  w_hs;
  logic                  w_last;
  logic                  w_ld_wr;
  logic                  w_ld_we;
  logic                  w_ld_drop;
  logic [HALFWORD_W-1:0] w_ld_wdata;
  logic                  w_arb_oor;
  logic                  w_arb_req;
  logic                  w_arb_re;
  logic                  w_arb_we;
  logic                  w_ram_we;
  logic                  w_ram_re;
  logic [AW-1:0]         w_ram_addr;
  logic [HALFWORD_W-1:0] w_ram_wdata;
  logic [HALFWORD_W-1:0] w_ram_q;

  // Loader write: a full pair in BYTE1, or a lone trailing byte in BYTE0.
  assign w_hs       = load_valid_i && r_ready;
  assign w_last     = (r_remaining == 16'd1);
  assign w_ld_wr    = w_hs && ((r_state == BYTE1) || ((r_state == BYTE0) && w_last));
  assign w_ld_wdata = (r_state == BYTE1) ? {r_hi, load_byte_i} : {load_byte_i, 8'h00};
  assign w_ld_drop  = w_ld_wr && r_ptr[AW];
  assign w_ld_we    = w_ld_wr && !r_ptr[AW];

  // Arbiter port: any set upper bit is out of range, no aliasing.
  assign w_arb_oor = |mem_addr_i[31:AW];
  assign w_arb_req = !r_busy && (mem_re_i || mem_we_i);
  assign w_arb_re  = !r_busy && mem_re_i;
  assign w_arb_we  = !r_busy && mem_we_i;

  // The loader owns the RAM for the whole time busy is high.
  assign w_ram_we    = r_busy ? w_ld_we : (w_arb_we && !w_arb_oor);
  assign w_ram_re    = w_arb_re && !w_arb_oor;
  assign w_ram_addr  = r_busy ? r_ptr[AW-1:0] : mem_addr_i[AW-1:0];
  assign w_ram_wdata = r_busy ? w_ld_wdata : mem_write_i;

  mem_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk_i   (clk_i),
    .we_i    (w_ram_we),
    .re_i    (w_ram_re),
    .addr_i  (w_ram_addr),
    .wdata_i (w_ram_wdata),
    .rdata_o (w_ram_q)
  );

  // Loader FSM with registered ready/busy/done.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= IDLE;
      r_remaining <= '0;
      r_ptr       <= '0;
      r_hi        <= '0;
      r_busy      <= 1'b0;
      r_ready     <= 1'b0;
      r_done      <= 1'b0;
      r_drop_seen <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (load_start_i) begin
            r_remaining <= load_len_i;
            r_ptr       <= '0;
            r_drop_seen <= 1'b0;
            r_busy      <= 1'b1;
            if (load_len_i == 16'd0) begin
              r_state <= DONE;
              r_ready <= 1'b0;
            end else begin
              r_state <= BYTE0;
              r_ready <= 1'b1;
            end
          end
        end
        BYTE0: begin
          if (w_hs) begin
            r_hi        <= load_byte_i;
            r_remaining <= r_remaining - 16'd1;
            if (w_last) begin
              r_state <= DONE;
              r_ready <= 1'b0;
            end else begin
              r_state <= BYTE1;
            end
          end
        end
        BYTE1: begin
          if (w_hs) begin
            r_remaining <= r_remaining - 16'd1;
            if (!r_ptr[AW]) begin
              r_ptr <= r_ptr + 1'b1;
            end
            if (w_last) begin
              r_state <= DONE;
              r_ready <= 1'b0;
            end else begin
              r_state <= BYTE0;
            end
          end
        end
        DONE: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
      if (w_ld_drop) begin
        r_drop_seen <= 1'b1;
      end
    end
  end

  // Read-data zero flag (reset / out-of-range read) and the one-cycle error pulse.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_zero <= 1'b1;
      r_err  <= 1'b0;
    end else begin
      if (w_arb_re) begin
        r_zero <= w_arb_oor;
      end
      r_err <= (w_arb_req && w_arb_oor) || (w_ld_drop && !r_drop_seen);
    end
  end

  assign data_o       = r_zero ? '0 : w_ram_q;
  assign addr_err_o   = r_err;
  assign load_ready_o = r_ready;
  assign load_busy_o  = r_busy;
  assign load_done_o  = r_done;

`ifdef MEM_LOAD_CHECKSUM_EN
  logic [15:0] r_csum;

  // Running byte sum, cleared when a load is accepted.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_csum <= '0;
    end else if ((r_state == IDLE) && load_start_i) begin
      r_csum <= '0;
    end else if (w_hs) begin
      r_csum <= r_csum + {8'h00, load_byte_i};
    end
  end

  assign checksum_o = r_csum;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed stimulus, a byte-index reference model
// checked every cycle, and literal expectations for key results.
module tb_mem_responder;

  localparam int DEPTH = 4096;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mem_addr;
  logic        mem_re;
  logic        mem_we;
  logic [15:0] mem_wdat;
  logic [15:0] data_o;
  logic        addr_err;
  logic        load_start;
  logic [15:0] load_len;
  logic [7:0]  load_byte;
  logic        load_valid;
  logic        load_ready;
  logic        load_busy;
  logic        load_done;
`ifdef MEM_LOAD_CHECKSUM_EN
  logic [15:0] checksum;
`endif

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;
  int done_cnt = 0;
  int err_cnt  = 0;
  logic [7:0] tx_q[$];

  always #5 clk = ~clk;

  mem_responder #(.DEPTH(DEPTH)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .mem_addr_i   (mem_addr),
    .mem_re_i     (mem_re),
    .mem_we_i     (mem_we),
    .mem_write_i  (mem_wdat),
    .data_o       (data_o),
    .addr_err_o   (addr_err),
    .load_start_i (load_start),
    .load_len_i   (load_len),
    .load_byte_i  (load_byte),
    .load_valid_i (load_valid),
    .load_ready_o (load_ready),
    .load_busy_o  (load_busy),
    .load_done_o  (load_done)
`ifdef MEM_LOAD_CHECKSUM_EN
    ,
    .checksum_o   (checksum)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s timed out t=%0t", name, $time);
  endtask

  // ---------------- reference model (byte-index view of the load) ----------------
  logic [15:0] m_mem [DEPTH];
  bit          m_known [DEPTH];
  logic [15:0] m_data;
  bit          m_data_known;
  bit          m_err, m_busy, m_ready, m_done, m_finish, m_drop_seen;
  int          m_len, m_k;
  logic [7:0]  m_pend;
  logic [15:0] m_csum;

  always @(posedge clk) begin : model
    bit n_err;
    bit n_done;
    int w;
    int a;
    logic [15:0] v;
    if (rst) begin
      m_data = '0; m_data_known = 1'b1; m_err = 1'b0; m_busy = 1'b0;
      m_ready = 1'b0; m_done = 1'b0; m_finish = 1'b0; m_csum = '0;
    end else begin
      n_err = 1'b0;
      n_done = 1'b0;
      // arbiter side: read-first, range-checked, ignored during a load
      if (!m_busy && (mem_re || mem_we)) begin
        if (mem_addr >= 32'(DEPTH)) begin
          n_err = 1'b1;
          if (mem_re) begin m_data = '0; m_data_known = 1'b1; end
        end else begin
          a = int'(mem_addr);
          if (mem_re) begin m_data = m_mem[a]; m_data_known = m_known[a]; end
          if (mem_we) begin m_mem[a] = mem_wdat; m_known[a] = 1'b1; end
        end
      end
      // loader side: byte k lands in word k/2, high lane when k is even
      if (m_finish) begin
        n_done = 1'b1; m_busy = 1'b0; m_finish = 1'b0;
      end else if (m_ready && load_valid) begin
        w = m_k / 2;
        v = 'x;
        if (m_k % 2 == 0) begin
          m_pend = load_byte;
          if (m_k == m_len - 1) v = {load_byte, 8'h00};
        end else begin
          v = {m_pend, load_byte};
        end
        if ((m_k % 2 == 1) || (m_k == m_len - 1)) begin
          if (w >= DEPTH) begin
            if (!m_drop_seen) begin n_err = 1'b1; m_drop_seen = 1'b1; end
          end else begin
            m_mem[w] = v; m_known[w] = 1'b1;
          end
        end
        m_csum = m_csum + 16'(load_byte);
        m_k++;
        if (m_k == m_len) begin m_ready = 1'b0; m_finish = 1'b1; end
      end else if (!m_busy && load_start) begin
        m_busy = 1'b1; m_len = int'(load_len); m_k = 0; m_drop_seen = 1'b0; m_csum = '0;
        if (load_len == 16'd0) m_finish = 1'b1;
        else m_ready = 1'b1;
      end
      m_err = n_err;
      m_done = n_done;
    end
  end

  // ---------------- per-cycle compare against the model ----------------
  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      chk("busy", 32'(load_busy), 32'(m_busy));
      chk("ready", 32'(load_ready), 32'(m_ready));
      chk("done", 32'(load_done), 32'(m_done));
      chk("addr_err", 32'(addr_err), 32'(m_err));
      if (m_data_known) chk("data_o", 32'(data_o), 32'(m_data));
`ifdef MEM_LOAD_CHECKSUM_EN
      chk("checksum", 32'(checksum), 32'(m_csum));
`endif
      if (load_done === 1'b1) done_cnt++;
      if (addr_err === 1'b1) err_cnt++;
    end
  end

  // ---------------- stimulus helpers (entered and left at a negedge) ----------------
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic wr(input logic [31:0] a, input logic [15:0] d);
    mem_addr = a; mem_wdat = d; mem_we = 1'b1;
    @(negedge clk);
    mem_we = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [15:0] exp, input string nm);
    mem_addr = a; mem_re = 1'b1;
    @(negedge clk);
    mem_re = 1'b0;
    chk(nm, 32'(data_o), 32'(exp));
  endtask

  task automatic do_load(input int len, input int nsend, input bit wait_done);
    int n;
    load_start = 1'b1; load_len = 16'(len);
    @(negedge clk);
    load_start = 1'b0;
    for (int i = 0; i < nsend; i++) begin
      load_byte = tx_q[i]; load_valid = 1'b1;
      n = 0;
      while (!load_ready && n < 50) begin @(negedge clk); n++; end
      if (n >= 50) begin timeout("load_ready"); break; end
      @(negedge clk);
    end
    load_valid = 1'b0;
    if (wait_done) begin
      n = 0;
      while (!load_done && n < 50) begin @(negedge clk); n++; end
      if (n >= 50) timeout("load_done");
    end
  endtask

  initial begin
    int d0;
    int e0;
    rst = 1'b1; mem_addr = '0; mem_re = 1'b0; mem_we = 1'b0; mem_wdat = '0;
    load_start = 1'b0; load_len = '0; load_byte = '0; load_valid = 1'b0;
    idle(3);
    chk("rst_data", 32'(data_o), 32'h0);
    chk("rst_err", 32'(addr_err), 32'h0);
    chk("rst_ready", 32'(load_ready), 32'h0);
    chk("rst_busy", 32'(load_busy), 32'h0);
    chk("rst_done", 32'(load_done), 32'h0);
    chk_en = 1'b1;
    rst = 1'b0;
    idle(2);

    // even-length load
    tx_q = '{8'h12, 8'h34, 8'h56, 8'h78};
    d0 = done_cnt;
    do_load(4, 4, 1'b1);
    chk("busy_drops_with_done", 32'(load_busy), 32'h0);
    idle(3);
    chk("done_pulses_len4", 32'(done_cnt - d0), 32'd1);
    rd(0, 16'h1234, "ram0_len4");
    rd(1, 16'h5678, "ram1_len4");

    // odd-length load: trailing byte lands in the high lane
    tx_q = '{8'hAA, 8'hBB, 8'hCC};
    do_load(3, 3, 1'b1);
    idle(2);
    rd(0, 16'hAABB, "ram0_len3");
    rd(1, 16'hCC00, "ram1_len3");

    // zero-length load: busy one cycle, then done
    d0 = done_cnt;
    load_start = 1'b1; load_len = 16'd0;
    @(negedge clk);
    load_start = 1'b0;
    chk("len0_busy", 32'(load_busy), 32'h1);
    chk("len0_no_done_yet", 32'(load_done), 32'h0);
    @(negedge clk);
    chk("len0_done", 32'(load_done), 32'h1);
    chk("len0_busy_low", 32'(load_busy), 32'h0);
    idle(2);
    chk("len0_done_pulses", 32'(done_cnt - d0), 32'd1);
    rd(1, 16'hCC00, "ram1_after_len0");

    // arbiter write / read / read-first
    wr(5, 16'hBEEF);
    rd(5, 16'hBEEF, "rd_after_wr");
    mem_addr = 5; mem_wdat = 16'h1111; mem_re = 1'b1; mem_we = 1'b1;
    @(negedge clk);
    mem_re = 1'b0; mem_we = 1'b0;
    chk("read_first", 32'(data_o), 32'hBEEF);
    rd(5, 16'h1111, "rd_after_rfw");

    // out-of-range access
    mem_addr = 32'(DEPTH); mem_wdat = 16'hDEAD; mem_re = 1'b1; mem_we = 1'b1;
    @(negedge clk);
    mem_re = 1'b0; mem_we = 1'b0;
    chk("oor_err", 32'(addr_err), 32'h1);
    chk("oor_data", 32'(data_o), 32'h0);
    @(negedge clk);
    chk("oor_err_one_cycle", 32'(addr_err), 32'h0);
    rd(0, 16'hAABB, "no_alias_ram0");

    // abort mid-load, with ignored arbiter traffic and an ignored start
    tx_q = '{8'h9A, 8'hBC, 8'h01, 8'h02, 8'h03, 8'h04};
    d0 = done_cnt;
    load_start = 1'b1; load_len = 16'd6;
    @(negedge clk);
    load_start = 1'b0;
    mem_addr = 5; mem_wdat = 16'h7777; mem_we = 1'b1;
    @(negedge clk);
    mem_we = 1'b0;
    mem_addr = 1; mem_re = 1'b1;
    @(negedge clk);
    mem_re = 1'b0;
    chk("busy_read_ignored", 32'(data_o), 32'hAABB);
    load_start = 1'b1; load_len = 16'd2;
    @(negedge clk);
    load_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      load_byte = tx_q[i]; load_valid = 1'b1;
      @(negedge clk);
    end
    load_valid = 1'b0;
    chk("still_busy_before_rst", 32'(load_busy), 32'h1);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    chk("abort_busy", 32'(load_busy), 32'h0);
    chk("abort_ready", 32'(load_ready), 32'h0);
    idle(4);
    chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
    rd(0, 16'h9ABC, "abort_pair_kept");
    rd(5, 16'h1111, "busy_write_ignored");
    rd(1, 16'hCC00, "abort_ram1_untouched");

    // checksum wrap-around pattern
    tx_q = '{8'hFF, 8'hFF, 8'h02};
    do_load(3, 3, 1'b1);
`ifdef MEM_LOAD_CHECKSUM_EN
    chk("checksum_ff_ff_02", 32'(checksum), 32'h0200);
`endif
    idle(2);
    rd(0, 16'hFFFF, "ram0_csum_load");
    rd(1, 16'h0200, "ram1_csum_load");

    // overflow: one pair beyond the end of the RAM
    tx_q.delete();
    for (int i = 0; i < 2 * DEPTH + 2; i++) tx_q.push_back(8'(i));
    e0 = err_cnt;
    do_load(2 * DEPTH + 2, 2 * DEPTH + 2, 1'b1);
`ifdef MEM_LOAD_CHECKSUM_EN
    chk("checksum_overflow_load", 32'(checksum), 32'hF001);
`endif
    idle(3);
    chk("overflow_err_once", 32'(err_cnt - e0), 32'd1);
    rd(0, 16'h0001, "overflow_ram0");
    rd(32'(DEPTH - 1), 16'hFEFF, "overflow_last_word");

    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the core's single shared 16-bit memory port; it answers the arbiter's halfword-addressed read and write requests.
- Holds a halfword-wide on-chip RAM with 1-cycle read latency.
- Includes a byte-stream program loader FSM that fills the RAM after reset, while the core is held off via load_busy_o.

Parameters:
- DEPTH, 4096, number of 16-bit halfwords in the RAM; must be a power of 2.
- AW, $clog2(DEPTH), number of RAM index bits used from mem_addr_i.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  reset; synchronous, active-high
- mem_addr_i  in  32  halfword address from the arbiter (already byte address >> 1)
- mem_re_i  in  1  read request
- mem_we_i  in  1  write request
- mem_write_i  in  16  write data
- data_o  out  16  read data, valid the cycle after mem_re_i
- addr_err_o  out  1  one-cycle pulse on an out-of-range access
- load_start_i  in  1  start a program load
- load_len_i  in  16  number of bytes to load, sampled on start
- load_byte_i  in  8  loader byte
- load_valid_i  in  1  loader byte valid
- load_ready_o  out  1  loader can accept a byte
- load_busy_o  out  1  load in progress; the core must be stalled
- load_done_o  out  1  one-cycle pulse when the load completes

Behaviour:
- Reset values: data_o=0, addr_err_o=0, load_ready_o=0, load_busy_o=0, load_done_o=0, FSM=IDLE. RAM contents are not cleared.
- Read: if mem_re_i=1 in cycle N, data_o = RAM[mem_addr_i[AW-1:0]] in cycle N+1. data_o holds its last value when there is no read.
- Write: if mem_we_i=1, RAM is written at the clock edge. If re and we are both set, the write happens and data_o returns the old word (read-first).
- Range check: mem_addr_i >= DEPTH means the write is dropped, the read returns 0 next cycle, and addr_err_o pulses in cycle N+1. The upper address bits are compared; there is no aliasing.
- Byte order: the first byte of each pair (even byte address) is stored in bits [15:8], the second in [7:0]. The arbiter swaps the bytes back.
- Loader FSM states: IDLE, BYTE0, BYTE1, DONE.
  - IDLE: when load_start_i=1, latch remaining=load_len_i and clear ptr=0. If load_len_i=0, go to DONE; otherwise go to BYTE0. load_busy_o goes high the cycle after start.
  - BYTE0 (load_ready_o=1): on valid, latch hi=byte and decrement remaining. If remaining was 1, write {byte,8'h00} at ptr, then go to DONE. Otherwise go to BYTE1.
  - BYTE1 (load_ready_o=1): on valid, write {hi,byte} at ptr, increment ptr and decrement remaining. Go to DONE if remaining was 1, else back to BYTE0.
  - DONE: drive load_done_o=1 for one cycle, clear load_busy_o, return to IDLE.
- A handshake occurs only when load_valid_i && load_ready_o. Back-to-back bytes every cycle are supported, giving 1 byte/cycle.
- If ptr reaches DEPTH, further writes are dropped, addr_err_o pulses once, and the FSM still consumes bytes until remaining=0.
- load_start_i while busy is ignored.
- While load_busy_o=1, arbiter requests are ignored: no write, data_o is unchanged, and there is no error.
- rst_i mid-load aborts to IDLE, drives busy=0, and generates no done pulse. Words already written remain in RAM.

Optional Feature:
- Macro MEM_LOAD_CHECKSUM_EN.
- With the macro defined:
  - An added output checksum_o [15:0] holds the 16-bit wrapping sum of all loaded bytes, zero-extended.
  - checksum_o is cleared on load start and on reset.
  - checksum_o is stable from the load_done_o pulse until the next start.
- Without the macro, the port and its logic are absent.

Decomposition:
- Package mem_pkg contains:
  - the loader state enum typedef (IDLE/BYTE0/BYTE1/DONE);
  - the localparam HALFWORD_W=16 and BYTE_W=8.
- One sub-module is natural: mem_ram.
  - Single-port, read-first, DEPTH×16 synchronous RAM with 1-cycle latency.
  - The top level muxes the loader write port and the arbiter port into it.

Test Plan:
- Reset, then load_len=4 with bytes 0x12,0x34,0x56,0x78 -> RAM[0]=0x1234, RAM[1]=0x5678, load_done_o pulses once, busy drops in the same cycle.
- Odd load, load_len=3 with bytes 0xAA,0xBB,0xCC -> RAM[1]=0xCC00. Then start with load_len=0 -> done pulses 1 cycle after busy with no writes.
- After load: write 0xBEEF @ addr 5, then read @ 5 in the next cycle -> data_o=0xBEEF one cycle later. Simultaneous re+we of 0x1111 @5 -> data_o=0xBEEF (old value).
- Read and write @ addr DEPTH (4096) -> addr_err_o pulses, read data_o=0, and RAM[0] is unchanged.
- rst_i asserted after 2 of 6 bytes -> FSM in IDLE, busy=0, no done pulse, RAM[0] keeps the loaded pair. A start while busy is ignored.
- With MEM_LOAD_CHECKSUM_EN: bytes 0xFF,0xFF,0x02 -> checksum_o=0x0200. Arbiter requests issued during busy are ignored.
